// File: rtl/fft_ctrl_pkg.sv
// Shared types and constants for the FFT frame controller.
package fft_ctrl_pkg;

    localparam int unsigned FFT_LEN      = 1024;
    localparam int unsigned LOG2_FFT_LEN = 10;
    localparam int unsigned SAMPLE_W     = 64;
    localparam int unsigned CHAN_W       = 8;
    localparam int unsigned FRAME_W      = 16;
    localparam int unsigned TAG_W        = 1 + CHAN_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/fft_tag_delay.sv
// Fixed-latency shift register that carries {valid, channel} alongside the
// sample RAM read so the FFT sink sees tags aligned with returned data.
module fft_tag_delay #(
    parameter int unsigned RAM_LAT = 2,
    parameter int unsigned W       = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_tag,
    output logic [W-1:0] o_tag
);

    logic [W-1:0] r_line [RAM_LAT];

    // Shift the tag one stage per cycle; reset empties the line.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < RAM_LAT; i++) begin
                r_line[i] <= '0;
            end
        end else begin
            r_line[0] <= i_tag;
            for (int unsigned i = 1; i < RAM_LAT; i++) begin
                r_line[i] <= r_line[i-1];
            end
        end
    end

    assign o_tag = r_line[RAM_LAT-1];

endmodule

// File: rtl/fft_frame_ctrl.sv
// Sequences overlapping frames from the sample RAM into the streaming FFT
// core, tracks returned bins per frame, and checks returned channel tags.
module fft_frame_ctrl #(
    parameter int unsigned FFT_LEN       = fft_ctrl_pkg::FFT_LEN,
    parameter int unsigned ADDR_W        = 16,
    parameter int unsigned RAM_LAT       = 2,
    parameter int unsigned DRAIN_TIMEOUT = 8192
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [15:0]                num_frames,
    input  logic [ADDR_W-1:0]          base_addr,
    input  logic [ADDR_W-1:0]          step,
    output logic                       busy,
    output logic                       done,
    output logic                       err_chan,
    output logic                       err_timeout,
    output logic                       rd_en,
    output logic [ADDR_W-1:0]          rd_addr,
    input  logic [63:0]                rd_data,
    output logic                       fft_rst_n,
    output logic                       fft_valid_in,
    output logic [7:0]                 fft_channel_in,
    output logic [63:0]                fft_d,
    input  logic                       fft_valid_out,
    input  logic [7:0]                 fft_channel_out,
    input  logic [63:0]                fft_q,
    output logic                       out_valid,
    output logic [15:0]                out_frame,
    output logic [$clog2(FFT_LEN)-1:0] out_bin,
    output logic                       out_last,
    output logic [63:0]                out_data
);
    import fft_ctrl_pkg::*;

    localparam int unsigned      BIN_W    = $clog2(FFT_LEN);
    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(FFT_LEN - 1);
    localparam logic [31:0]      TMO_LAST = 32'(DRAIN_TIMEOUT - 1);

    state_t               r_state;
    logic [FRAME_W-1:0]   r_num_frames;
    logic [ADDR_W-1:0]    r_step;
    logic [ADDR_W-1:0]    r_frame_base;
    logic [ADDR_W-1:0]    r_rd_addr;
    logic [BIN_W-1:0]     r_sample;
    logic [FRAME_W-1:0]   r_frame;
    logic [31:0]          r_timer;
    logic                 r_done;
    logic                 r_err_timeout;
    logic                 r_fft_rst_n;

    logic [BIN_W-1:0]     r_bin;
    logic [FRAME_W-1:0]   r_oframe;
    logic                 r_err_chan;
    logic                 r_all_out;
    logic                 r_out_valid;
    logic [FRAME_W-1:0]   r_out_frame;
    logic [BIN_W-1:0]     r_out_bin;
    logic                 r_out_last;
    logic [SAMPLE_W-1:0]  r_out_data;

    logic                 w_rd_en;
    logic                 w_start_acc;
    logic                 w_feed_end;
    logic                 w_count;
    logic                 w_last_out;
    logic [CHAN_W-1:0]    w_chan;

    assign w_rd_en     = (r_state == FEED);
    assign w_start_acc = start && (r_state == IDLE);
    assign w_feed_end  = (r_sample == LAST_BIN) && (r_frame == r_num_frames - 16'd1);
    assign w_count     = fft_valid_out && (r_state != IDLE);
    assign w_last_out  = w_count && (r_bin == LAST_BIN) && (r_oframe == r_num_frames - 16'd1);
    assign w_chan      = w_rd_en ? r_frame[CHAN_W-1:0] : '0;

    // Control FSM: latches the command, walks read addresses, waits for drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_num_frames  <= '0;
            r_step        <= '0;
            r_frame_base  <= '0;
            r_rd_addr     <= '0;
            r_sample      <= '0;
            r_frame       <= '0;
            r_timer       <= '0;
            r_done        <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_num_frames  <= num_frames;
                        r_step        <= step;
                        r_frame_base  <= base_addr;
                        r_rd_addr     <= base_addr;
                        r_sample      <= '0;
                        r_frame       <= '0;
                        r_err_timeout <= 1'b0;
                        if (num_frames == 16'd0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= FEED;
                        end
                    end
                end
                FEED: begin
                    if (w_feed_end) begin
                        r_state <= DRAIN;
                        r_timer <= '0;
                    end else if (r_sample == LAST_BIN) begin
                        r_sample     <= '0;
                        r_frame      <= r_frame + 16'd1;
                        r_frame_base <= r_frame_base + r_step;
                        r_rd_addr    <= r_frame_base + r_step;
                    end else begin
                        r_sample  <= r_sample + BIN_W'(1);
                        r_rd_addr <= r_rd_addr + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    // A final bin arriving on the expiry cycle holds the timer
                    // so the run completes one cycle later instead of aborting.
                    if (r_all_out) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end else if (r_timer == TMO_LAST) begin
                        if (!w_last_out) begin
                            r_state       <= IDLE;
                            r_done        <= 1'b1;
                            r_err_timeout <= 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + 32'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Output-side bin/frame tracking, channel check and registered bin output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin       <= '0;
            r_oframe    <= '0;
            r_err_chan  <= 1'b0;
            r_all_out   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_frame <= '0;
            r_out_bin   <= '0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= w_count;
            r_out_data  <= fft_q;
            r_out_last  <= w_last_out;
            if (w_count) begin
                r_out_bin   <= r_bin;
                r_out_frame <= r_oframe;
                if ((r_bin == '0) && (fft_channel_out != r_oframe[CHAN_W-1:0])) begin
                    r_err_chan <= 1'b1;
                end
                if (w_last_out) begin
                    r_all_out <= 1'b1;
                end
                if (r_bin == LAST_BIN) begin
                    r_bin    <= '0;
                    r_oframe <= r_oframe + 16'd1;
                end else begin
                    r_bin <= r_bin + BIN_W'(1);
                end
            end
            if (w_start_acc) begin
                r_bin      <= '0;
                r_oframe   <= '0;
                r_err_chan <= 1'b0;
                r_all_out  <= 1'b0;
            end
        end
    end

    // FFT core reset follows the system reset one cycle later.
    always_ff @(posedge clk) begin
        r_fft_rst_n <= ~rst;
    end

    fft_tag_delay #(
        .RAM_LAT (RAM_LAT),
        .W       (TAG_W)
    ) u_tag_delay (
        .clk   (clk),
        .rst   (rst),
        .i_tag ({w_rd_en, w_chan}),
        .o_tag ({fft_valid_in, fft_channel_in})
    );

    assign busy        = (r_state != IDLE);
    assign done        = r_done;
    assign err_chan    = r_err_chan;
    assign err_timeout = r_err_timeout;
    assign rd_en       = w_rd_en;
    assign rd_addr     = r_rd_addr;
    assign fft_rst_n   = r_fft_rst_n;
    assign fft_d       = rd_data;
    assign out_valid   = r_out_valid;
    assign out_frame   = r_out_frame;
    assign out_bin     = r_out_bin;
    assign out_last    = r_out_last;
    assign out_data    = r_out_data;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Scoreboard bench for fft_frame_ctrl with a sample RAM model and a
// fixed-latency FFT core stand-in that returns inverted samples.
module tb_fft_frame_ctrl;

    localparam int N   = 1024;
    localparam int TMO = 8192;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] num_frames = '0;
    logic [15:0] base_addr = '0;
    logic [15:0] step = '0;
    logic        busy, done, err_chan, err_timeout, rd_en;
    logic [15:0] rd_addr;
    logic [63:0] rd_data;
    logic        fft_rst_n, fft_valid_in;
    logic [7:0]  fft_channel_in;
    logic [63:0] fft_d;
    logic        fft_valid_out;
    logic [7:0]  fft_channel_out;
    logic [63:0] fft_q;
    logic        out_valid;
    logic [15:0] out_frame;
    logic [9:0]  out_bin;
    logic        out_last;
    logic [63:0] out_data;

    fft_frame_ctrl #(
        .FFT_LEN       (N),
        .ADDR_W        (16),
        .RAM_LAT       (2),
        .DRAIN_TIMEOUT (TMO)
    ) dut (
        .clk (clk), .rst (rst), .start (start), .num_frames (num_frames),
        .base_addr (base_addr), .step (step), .busy (busy), .done (done),
        .err_chan (err_chan), .err_timeout (err_timeout), .rd_en (rd_en),
        .rd_addr (rd_addr), .rd_data (rd_data), .fft_rst_n (fft_rst_n),
        .fft_valid_in (fft_valid_in), .fft_channel_in (fft_channel_in),
        .fft_d (fft_d), .fft_valid_out (fft_valid_out),
        .fft_channel_out (fft_channel_out), .fft_q (fft_q),
        .out_valid (out_valid), .out_frame (out_frame), .out_bin (out_bin),
        .out_last (out_last), .out_data (out_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] ram_word(input logic [15:0] a);
        return {a ^ 16'h5A5A, 16'(a * 16'd7), a ^ 16'hC3C3, a};
    endfunction

    // Sample RAM with two cycles of read latency.
    logic [63:0] rp0 = '0, rp1 = '0;
    always @(posedge clk) begin
        rp0 <= rd_en ? ram_word(rd_addr) : 64'd0;
        rp1 <= rp0;
    end
    assign rd_data = rp1;

    // FFT stand-in: three-cycle pipe, inverted data, optional corruption.
    bit suppress = 1'b0;
    bit bad_chan = 1'b0;
    logic [72:0] fp0 = '0, fp1 = '0, fp2 = '0;
    always @(posedge clk) begin
        if (fft_rst_n !== 1'b1) begin
            fp0 <= '0; fp1 <= '0; fp2 <= '0;
        end else begin
            fp0 <= {fft_valid_in, fft_channel_in, fft_d};
            fp1 <= fp0;
            fp2 <= fp1;
        end
    end
    assign fft_valid_out   = fp2[72] && !suppress;
    assign fft_channel_out = (bad_chan && fp2[71:64] == 8'd1) ? 8'd5 : fp2[71:64];
    assign fft_q           = ~fp2[63:0];

    typedef struct {
        logic [15:0] fr;
        logic [9:0]  bin;
        logic        last;
        logic [63:0] d;
    } out_t;

    logic [15:0] q_rd[$];
    logic [71:0] q_in[$];
    out_t        q_out[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    int first_rd, first_vin, last_rd, rd_idx, vrun, vmax;
    int done_cnt = 0, done_cyc = 0, last_ol_cyc = 0;
    logic [15:0] fstart [4];
    logic [15:0] m_a;
    logic [71:0] m_i;
    out_t        m_o;

    // Monitor: pops expectations whenever the DUT presents a strobe.
    always @(posedge clk) begin
        #1;
        if (rd_en === 1'b1) begin
            if (q_rd.size() == 0) chk("rd_unexpected", rd_en, 1'b0);
            else begin
                m_a = q_rd.pop_front();
                chk("rd_addr", rd_addr, m_a);
            end
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
            if (rd_idx % N == 0 && rd_idx / N < 4) fstart[rd_idx / N] = rd_addr;
            rd_idx++;
        end
        if (fft_valid_in === 1'b1) begin
            if (q_in.size() == 0) chk("vin_unexpected", fft_valid_in, 1'b0);
            else begin
                m_i = q_in.pop_front();
                chk("chan_in", fft_channel_in, m_i[71:64]);
                chk("fft_d", fft_d, m_i[63:0]);
            end
            if (first_vin < 0) first_vin = cyc;
            vrun++;
            if (vrun > vmax) vmax = vrun;
        end else vrun = 0;
        if (out_valid === 1'b1) begin
            if (q_out.size() == 0) chk("out_unexpected", out_valid, 1'b0);
            else begin
                m_o = q_out.pop_front();
                chk("out_frame", out_frame, m_o.fr);
                chk("out_bin", out_bin, m_o.bin);
                chk("out_last", out_last, m_o.last);
                chk("out_data", out_data, m_o.d);
            end
            if (out_last === 1'b1) last_ol_cyc = cyc;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic reset_tracking();
        first_rd = -1; first_vin = -1; last_rd = 0; rd_idx = 0; vrun = 0; vmax = 0;
        for (int i = 0; i < 4; i++) fstart[i] = 16'hxxxx;
    endtask

    task automatic push_run(input int nf, input logic [15:0] b, input logic [15:0] st, input bit outs);
        logic [15:0] a;
        out_t o;
        for (int f = 0; f < nf; f++) begin
            for (int s = 0; s < N; s++) begin
                a = b + 16'(f) * st + 16'(s);
                q_rd.push_back(a);
                q_in.push_back({8'(f), ram_word(a)});
                if (outs) begin
                    o.fr = 16'(f); o.bin = 10'(s);
                    o.last = (f == nf - 1) && (s == N - 1);
                    o.d = ~ram_word(a);
                    q_out.push_back(o);
                end
            end
        end
    endtask

    task automatic do_start(input int nf, input logic [15:0] b, input logic [15:0] st);
        @(negedge clk);
        num_frames = 16'(nf); base_addr = b; step = st; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", done_cnt, d0 + 1);
        repeat (10) @(negedge clk);
        chk("single_done", done_cnt, d0 + 1);
        chk("q_rd_empty", q_rd.size(), 0);
        chk("q_in_empty", q_in.size(), 0);
        chk("q_out_empty", q_out.size(), 0);
        chk("busy_after", busy, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        reset_tracking();
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rd_en", rd_en, 1'b0);
        chk("rst_rd_addr", rd_addr, 16'd0);
        chk("rst_vin", fft_valid_in, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_errs", {err_chan, err_timeout}, 2'b00);
        chk("rst_fft_rst_n", fft_rst_n, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("fft_rst_n_rel", fft_rst_n, 1'b1);

        // Single frame, base 0.
        reset_tracking();
        push_run(1, 16'h0000, 16'd1024, 1'b1);
        do_start(1, 16'h0000, 16'd1024);
        chk("busy_feed", busy, 1'b1);
        wait_done(3000);
        chk("vin_latency", first_vin - first_rd, 2);
        chk("t1_start_addr", fstart[0], 16'h0000);
        chk("done_after_last", done_cyc - last_ol_cyc, 1);

        // Three overlapping frames wrapping the address space; start while busy.
        reset_tracking();
        push_run(3, 16'hFF00, 16'd512, 1'b1);
        do_start(3, 16'hFF00, 16'd512);
        repeat (1500) @(negedge clk);
        do_start(7, 16'h1234, 16'd16);
        chk("busy_ignore", busy, 1'b1);
        wait_done(6000);
        chk("fstart0", fstart[0], 16'hFF00);
        chk("fstart1", fstart[1], 16'h0100);
        chk("fstart2", fstart[2], 16'h0300);
        chk("vin_no_gap", vmax, 3 * N);

        // Zero frames.
        reset_tracking();
        d0 = done_cnt;
        do_start(0, 16'h0000, 16'd1024);
        chk("zero_done", done, 1'b1);
        chk("zero_busy", busy, 1'b0);
        @(negedge clk);
        chk("zero_done_pulse", done, 1'b0);
        repeat (5) @(negedge clk);
        chk("zero_done_cnt", done_cnt, d0 + 1);

        // Corrupted channel tag on frame 1.
        reset_tracking();
        bad_chan = 1'b1;
        push_run(2, 16'h0000, 16'd1024, 1'b1);
        do_start(2, 16'h0000, 16'd1024);
        wait_done(5000);
        chk("err_chan_set", err_chan, 1'b1);
        chk("err_timeout_clr", err_timeout, 1'b0);
        bad_chan = 1'b0;

        // No FFT output: drain timeout.
        reset_tracking();
        suppress = 1'b1;
        push_run(1, 16'h0040, 16'd1024, 1'b0);
        do_start(1, 16'h0040, 16'd1024);
        chk("err_chan_cleared", err_chan, 1'b0);
        wait_done(N + TMO + 200);
        chk("timeout_cycles", done_cyc - last_rd, TMO + 1);
        chk("err_timeout_set", err_timeout, 1'b1);
        suppress = 1'b0;

        // Reset in the middle of FEED.
        reset_tracking();
        push_run(2, 16'h0000, 16'd1024, 1'b1);
        do_start(2, 16'h0000, 16'd1024);
        repeat (200) @(negedge clk);
        d0 = done_cnt;
        rst = 1'b1;
        q_rd.delete(); q_in.delete(); q_out.delete();
        @(negedge clk);
        chk("mid_rst_rd_en", rd_en, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_fft_rst_n", fft_rst_n, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("mid_rst_no_done", done_cnt, d0);
        chk("mid_rst_fft_rel", fft_rst_n, 1'b1);
        chk("mid_rst_idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fft_frame_ctrl.md
Name: fft_frame_ctrl

Overview:
- Sequences the 1024-point streaming FFT core in the FDAS datapath.
- On a start command it reads num_frames overlapping 1024-sample frames from the sample buffer RAM and streams them into the FFT sink interface, tagging each frame with a channel number.
- It counts and tags FFT output bins, checks the returned channel tags, and signals completion when the last output bin has left the core.

Parameters:
- FFT_LEN, 1024, points per frame; power of two.
- ADDR_W, 16, sample buffer address width.
- RAM_LAT, 2, sample RAM read latency in cycles; must be ≥1.
- DRAIN_TIMEOUT, 8192, maximum cycles allowed in DRAIN before abort.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  single-cycle command pulse; sampled only in IDLE.
- num_frames  in  16  frames to process; latched on start.
- base_addr  in  ADDR_W  address of the first sample; latched on start.
- step  in  ADDR_W  address stride between frame starts (overlap = FFT_LEN-step); latched on start.
- busy  out  1  high while not IDLE.
- done  out  1  one-cycle pulse when a run completes or aborts.
- err_chan  out  1  sticky channel-tag mismatch; cleared on start.
- err_timeout  out  1  sticky drain timeout; cleared on start.
- rd_en  out  1  sample RAM read strobe.
- rd_addr  out  ADDR_W  sample RAM read address.
- rd_data  in  64  sample RAM data, valid RAM_LAT cycles after rd_en.
- fft_rst_n  out  1  FFT core reset; registered inverse of rst.
- fft_valid_in  out  1  FFT sink valid.
- fft_channel_in  out  8  FFT sink channel.
- fft_d  out  64  FFT sink data (complex sample).
- fft_valid_out  in  1  FFT source valid.
- fft_channel_out  in  8  FFT source channel.
- fft_q  in  64  FFT source data.
- out_valid  out  1  output bin valid.
- out_frame  out  16  frame index of the output bin.
- out_bin  out  10  bin index, 0 to FFT_LEN-1.
- out_last  out  1  marks the last bin of the last frame.
- out_data  out  64  fft_q, registered.

Behaviour:
- Reset values:
  - All outputs are 0, except fft_rst_n, which is 0 during rst and 1 on the cycle after rst falls.
  - The state machine returns to IDLE and all counters clear.
  - rst mid-run aborts the run with no done pulse; the FFT core is reset through fft_rst_n.
- States and transitions:
  - IDLE: on start, latch the inputs and clear both error flags. If num_frames=0, pulse done on the next cycle and stay in IDLE. Otherwise go to FEED.
  - FEED: rd_en=1 every cycle, frames issued back-to-back with no gaps. rd_addr = base_addr + frame*step + sample, modulo 2^ADDR_W (wraps silently). When sample=FFT_LEN-1 and frame=num_frames-1, go to DRAIN.
  - DRAIN: rd_en=0. Leave when the output frame count reaches num_frames, or when DRAIN_TIMEOUT cycles elapse (set err_timeout). In either case pulse done and return to IDLE.
- Input pipeline:
  - fft_valid_in and fft_channel_in (= frame[7:0]) are rd_en and its tag delayed by exactly RAM_LAT cycles.
  - fft_d = rd_data, combinational pass-through.
  - A delay line carries the tags, so there is no bubble between frames.
- Output tracking:
  - fft_valid_out is counted only in FEED or DRAIN; it is ignored in IDLE.
  - Each output is registered: 1 cycle latency to out_valid, out_data, out_bin and out_frame.
  - The bin counter wraps at FFT_LEN-1 and then increments the frame counter.
  - At bin 0, compare fft_channel_out with out_frame[7:0]; set err_chan on mismatch. Processing continues.
  - out_last = 1 at bin FFT_LEN-1 of frame num_frames-1.
  - done asserts on the cycle after out_last, concurrently with the return to IDLE.
- Simultaneous events:
  - The final fft_valid_out coinciding with the timeout expiry counts as completion, not timeout.
  - start while busy is ignored.
  - start and rst together: rst wins.
- num_frames=65535 must not overflow the 16-bit frame counters. Comparisons use frame = num_frames-1, not frame+1 = num_frames.

Decomposition:
- Package fft_ctrl_pkg: state enum (IDLE, FEED, DRAIN), FFT_LEN, LOG2_FFT_LEN, sample width constant (64), channel width (8).
- Sub-module fft_tag_delay: parameterised RAM_LAT shift register carrying {valid, channel}.

Test Plan:
1. rst, then start with num_frames=1, base=0, step=1024, RAM_LAT=2:
   - rd_addr runs 0..1023 on consecutive cycles.
   - fft_valid_in rises 2 cycles after rd_en, channel 0.
   - 1024 out_valid with out_bin 0..1023; one done pulse after out_last.
2. num_frames=3, base=0xFF00, step=512:
   - frame-start addresses are 0xFF00, 0x0100, 0x0300 (wrap).
   - channels in are 0, 1, 2 with no gap at frame boundaries.
   - out_frame runs 0..2.
3. num_frames=0 -> done one cycle after start, no rd_en, busy stays 0.
4. Return fft_channel_out=5 for frame 1 -> err_chan=1 persists through done; next start clears it.
5. Model suppresses all FFT outputs -> err_timeout=1 and done exactly DRAIN_TIMEOUT cycles after entering DRAIN.
6. rst asserted mid-FEED -> next cycle rd_en=0, busy=0, fft_rst_n=0; no done pulse. Start pulse during busy -> ignored; latched num_frames unchanged.
